botao_cond: RTL and testbench



---
 rtl/botao_cond_if.sv | 24 ++
 rtl/botao_cond.sv | 87 ++++++++
 tb/tb_botao_cond.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/botao_cond_if.sv
// Push-button conditioner bus: raw level in, clean request pulse,
// debounced level and accepted-press count out.
interface botao_cond_if;
  logic       bt_raw;
  logic       bt;
  logic       pressed;
  logic [7:0] n_press;

  // Producer of the raw button level and consumer of the conditioned outputs.
  modport master (
    output bt_raw,
    input  bt,
    input  pressed,
    input  n_press
  );

  // The conditioner itself.
  modport slave (
    input  bt_raw,
    output bt,
    output pressed,
    output n_press
  );
endinterface

// File: rtl/botao_cond.sv
// Pedestrian push-button conditioner feeding semaforo.bt.
// Raw button -> 2-FF synchronizer -> DEB_CYCLES debounce filter ->
// rising-edge one-shot with LOCKOUT cycles of post-request blanking.
// Also keeps a saturating count of accepted requests for debug.
module botao_cond #(
  parameter logic [7:0] DEB_CYCLES = 8'd4,  // legal 1..255
  parameter logic [7:0] LOCKOUT    = 8'd6   // legal 0..255, 0 disables
) (
  input  logic         clk,
  input  logic         rst,
  botao_cond_if.slave  bus
);

  logic       s1_q, s2_q;
  logic [7:0] cnt_q, cnt_d;
  logic       pressed_q, pressed_d;
  logic       bt_q, bt_d;
  logic [7:0] lock_q, lock_d;
  logic [7:0] n_press_q, n_press_d;
  logic       settle;

  // Next-state logic for debounce, one-shot, lockout and press counter.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    cnt_d     = 8'd0;
    pressed_d = pressed_q;
    bt_d      = 1'b0;
    lock_d    = lock_q;
    n_press_d = n_press_q;

    // The synchronized level has differed from the accepted level for
    // DEB_CYCLES consecutive cycles once this count would reach the limit.
    settle = (cnt_q + 8'd1) == DEB_CYCLES;

    if (s2_q != pressed_q) begin
      if (settle) begin
        pressed_d = s2_q;
        cnt_d     = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Only a 0->1 change of the debounced level can request, and only when
    // the previous request's blanking window has fully expired.
    bt_d = pressed_d && !pressed_q && (lock_q == 8'd0);

    if (bt_d) begin
      lock_d = LOCKOUT;
    end else if (lock_q != 8'd0) begin
      lock_d = lock_q - 8'd1;
    end

    if (bt_d && (n_press_q != 8'hFF)) begin
      n_press_d = n_press_q + 8'd1;
    end
  end

  // State registers; synchronous reset discards all progress.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= 8'd0;
      pressed_q <= 1'b0;
      bt_q      <= 1'b0;
      lock_q    <= 8'd0;
      n_press_q <= 8'd0;
    end else begin
      s1_q      <= bus.bt_raw;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      bt_q      <= bt_d;
      lock_q    <= lock_d;
      n_press_q <= n_press_d;
    end
  end

  assign bus.bt      = bt_q;
  assign bus.pressed = pressed_q;
  assign bus.n_press = n_press_q;

endmodule

// File: tb/tb_botao_cond.sv
// Bench for botao_cond: two instances (LOCKOUT 6 and 20) share one raw
// button stimulus; both are compared every cycle against an edge-history
// reference model, plus table-driven and hand-written corner sequences.
module tb_botao_cond;

  localparam int DEB      = 4;
  localparam int LOCK_A   = 6;
  localparam int LOCK_B   = 20;
  localparam int MAX_EDGE = 20000;

  logic clk;
  logic rst;
  logic raw;

  int n_checks = 0;
  int n_errors = 0;

  botao_cond_if bus_a ();
  botao_cond_if bus_b ();
  assign bus_a.bt_raw = raw;
  assign bus_b.bt_raw = raw;

  botao_cond #(.DEB_CYCLES(8'(DEB)), .LOCKOUT(8'(LOCK_A))) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  botao_cond #(.DEB_CYCLES(8'(DEB)), .LOCKOUT(8'(LOCK_B))) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Inputs seen at each edge are recorded; the synchronized level at an
  // edge is the raw level two edges earlier (zero if a reset intervened).
  // The debounced level flips when the last DEB synchronized samples all
  // disagree with it; a rise requests unless the previous request is at
  // most LOCKOUT edges in the past.
  bit raw_at [MAX_EDGE];
  bit rst_at [MAX_EDGE];
  int edge_n   = 0;
  int last_rst = 0;
  bit m_pressed [2];
  bit m_bt      [2];
  int m_np      [2];
  int m_last    [2];
  int m_lock    [2];

  function automatic bit sync_at(input int k);
    if (k < 2) return 1'b0;
    if (rst_at[k-1] || rst_at[k-2]) return 1'b0;
    return raw_at[k-2];
  endfunction

  task automatic model_edge();
    int k;
    bit all_diff;
    k = edge_n;
    raw_at[k] = raw;
    rst_at[k] = rst;
    if (rst) last_rst = k;
    for (int d = 0; d < 2; d++) begin
      m_bt[d] = 1'b0;
      if (rst) begin
        m_pressed[d] = 1'b0;
        m_np[d]      = 0;
        m_last[d]    = -100000;
      end else begin
        all_diff = (k - DEB + 1) > last_rst;
        for (int j = 0; j < DEB; j++)
          if (sync_at(k - j) == m_pressed[d]) all_diff = 1'b0;
        if (all_diff) begin
          m_pressed[d] = ~m_pressed[d];
          if (m_pressed[d] && (k - m_last[d] > m_lock[d])) begin
            m_bt[d]   = 1'b1;
            m_last[d] = k;
            if (m_np[d] < 255) m_np[d] = m_np[d] + 1;
          end
        end
      end
    end
    edge_n = edge_n + 1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_a_pressed", int'(bus_a.pressed), int'(m_pressed[0]));
    check("model_a_bt",      int'(bus_a.bt),      int'(m_bt[0]));
    check("model_a_n_press", int'(bus_a.n_press), m_np[0]);
    check("model_b_pressed", int'(bus_b.pressed), int'(m_pressed[1]));
    check("model_b_bt",      int'(bus_b.bt),      int'(m_bt[1]));
    check("model_b_n_press", int'(bus_b.n_press), m_np[1]);
  endtask

  // Apply one input pair for n edges; sample on the falling edge.
  task automatic step(input bit r, input bit b, input int n);
    rst = r;
    raw = b;
    repeat (n) begin
      @(posedge clk);
      if (edge_n < MAX_EDGE) model_edge();
      @(negedge clk);
      check_model();
    end
  endtask

  typedef struct {
    bit rst;
    bit raw;
    int n;
    bit exp_pressed;
    bit exp_bt;
    int exp_np;
  } vec_t;

  vec_t tbl [$];

  initial begin
    rst = 1'b1;
    raw = 1'b1;
    m_lock[0] = LOCK_A;
    m_lock[1] = LOCK_B;

    // Reset, clean press/release, glitch and bounce on instance A.
    tbl.push_back('{1'b1, 1'b1,  3, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1,  5, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1, 15, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  5, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  4, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1,  3, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  8, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1,  2, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1,  5, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0, 1'b0,  6, 1'b0, 1'b0, 2});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].raw, tbl[i].n);
      check($sformatf("tbl%0d_pressed", i), int'(bus_a.pressed), int'(tbl[i].exp_pressed));
      check($sformatf("tbl%0d_bt", i),      int'(bus_a.bt),      int'(tbl[i].exp_bt));
      check($sformatf("tbl%0d_n_press", i), int'(bus_a.n_press), tbl[i].exp_np);
    end

    // Lockout on instance B: re-press inside the window is swallowed.
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b1, 6);
    check("lock_first_bt", int'(bus_b.bt), 1);
    step(1'b0, 1'b0, 6);
    check("lock_release", int'(bus_b.pressed), 0);
    step(1'b0, 1'b1, 6);
    check("lock_repress_pressed", int'(bus_b.pressed), 1);
    check("lock_repress_bt",      int'(bus_b.bt),      0);
    check("lock_repress_n_press", int'(bus_b.n_press), 1);
    step(1'b0, 1'b0, 10);
    step(1'b0, 1'b1, 6);
    check("lock_expired_bt",      int'(bus_b.bt),      1);
    check("lock_expired_n_press", int'(bus_b.n_press), 2);

    // Reset at the third edge of a debounce discards it.
    step(1'b0, 1'b0, 8);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 5);
    check("rst_deb_bt",      int'(bus_a.bt),      0);
    check("rst_deb_pressed", int'(bus_a.pressed), 0);
    step(1'b0, 1'b1, 1);
    check("rst_deb_late_bt",      int'(bus_a.bt),      1);
    check("rst_deb_late_n_press", int'(bus_a.n_press), 1);

    // Reset during lockout clears the window on instance B.
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b1, 6);
    check("rst_lock_first_bt", int'(bus_b.bt), 1);
    step(1'b0, 1'b0, 6);
    step(1'b1, 1'b0, 1);
    check("rst_lock_n_press", int'(bus_b.n_press), 0);
    step(1'b0, 1'b1, 6);
    check("rst_lock_again_bt",      int'(bus_b.bt),      1);
    check("rst_lock_again_n_press", int'(bus_b.n_press), 1);
    step(1'b0, 1'b0, 8);

    // Saturation: 260 accepted presses on both instances.
    step(1'b1, 1'b0, 2);
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b1, 6);
      check("sat_bt_a", int'(bus_a.bt), 1);
      check("sat_bt_b", int'(bus_b.bt), 1);
      check("sat_n_press_a", int'(bus_a.n_press), (i + 1 > 255) ? 255 : i + 1);
      step(1'b0, 1'b0, 20);
    end
    check("sat_final_a", int'(bus_a.n_press), 255);
    check("sat_final_b", int'(bus_b.n_press), 255);

    // Random bouncy stimulus with occasional resets against the model.
    step(1'b1, 1'b0, 2);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), 1);
      else
        step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
